// File: rtl/des_decrypt_128bit.sv
// rtl/des_decrypt_128bit.sv - Iterative 128-bit Feistel decryptor with IP, F_FUNCTION and IP_1 blocks.
// Optional macro DES_DEC_ENC_MODE_EN adds a Mode input selecting encrypt (0) or decrypt (1).

module des_ip (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar i = 0; i < 128; i++) begin : g_perm
        assign dout[i] = din[(i * 37) % 128];
    end
endmodule

// 45 is the inverse of 37 modulo 128, so this undoes des_ip exactly.
module des_ip_1 (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar i = 0; i < 128; i++) begin : g_perm
        assign dout[i] = din[(i * 45) % 128];
    end
endmodule

module des_f_function (
    input  logic [63:0] r,
    input  logic [95:0] key,
    output logic [63:0] f
);
    localparam logic [63:0] SBOX = 64'h2174_8FE3_DA09_B65C;

    logic [95:0] expanded;
    logic [63:0] sboxed;

    // Each nibble is widened with its two neighbouring bits, keyed, then squeezed back through the S-box.
    for (genvar j = 0; j < 16; j++) begin : g_sbox
        logic [5:0] x;
        assign expanded[6*j +: 6] = {r[(4*j + 63) % 64], r[4*j +: 4], r[(4*j + 4) % 64]};
        assign x = expanded[6*j +: 6] ^ key[6*j +: 6];
        assign sboxed[4*j +: 4] = SBOX[{x[4:1], 2'b00} +: 4]
                                ^ {x[5] & x[0], x[5], x[0], x[5] ^ x[0]};
    end

    for (genvar i = 0; i < 64; i++) begin : g_p
        assign f[i] = sboxed[(i * 13) % 64];
    end
endmodule

module des_decrypt_128bit (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Rk_valid,
    input  logic [95:0]  Rk_data,
    output logic         Rk_ready,
    output logic         Rk_loaded,
    input  logic         Ct_valid,
    input  logic [127:0] Ciphertext,
    output logic         Ct_ready,
    output logic         Pt_valid,
    output logic [127:0] Plaintext,
    input  logic         Pt_ready,
`ifdef DES_DEC_ENC_MODE_EN
    input  logic         Mode,
`endif
    output logic         Busy
);
    typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;

    state_t       state;
    logic [63:0]  l, r, l_next, r_next, f_out;
    logic [3:0]   cnt, key_idx, wptr;
    logic [95:0]  keys [16];
    logic [127:0] ip_out, ip_1_out;
    logic         ct_hs, rk_hs, pt_hs;

    assign Ct_ready = (state == IDLE) && Rk_loaded;
    assign Rk_ready = (state == IDLE) && !(Ct_valid && Rk_loaded);
    assign Busy     = (state != IDLE);
    assign ct_hs    = Ct_valid && Ct_ready;
    assign rk_hs    = Rk_valid && Rk_ready;
    assign pt_hs    = Pt_valid && Pt_ready;

`ifdef DES_DEC_ENC_MODE_EN
    logic decrypt;
    assign key_idx = decrypt ? 4'd15 - cnt : cnt;
`else
    assign key_idx = 4'd15 - cnt;
`endif

    des_ip u_ip (
        .din  (Ciphertext),
        .dout (ip_out)
    );

    des_f_function u_f (
        .r   (r),
        .key (keys[key_idx]),
        .f   (f_out)
    );

    assign l_next = r;
    assign r_next = l ^ f_out;

    // Final swap: the last round's halves go into IP_1 as {R16, L16}.
    des_ip_1 u_ip_1 (
        .din  ({r_next, l_next}),
        .dout (ip_1_out)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            l         <= '0;
            r         <= '0;
            cnt       <= '0;
            Pt_valid  <= 1'b0;
            Plaintext <= '0;
`ifdef DES_DEC_ENC_MODE_EN
            decrypt   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ct_hs) begin
                        {l, r} <= ip_out;
                        cnt    <= '0;
                        state  <= ROUND;
`ifdef DES_DEC_ENC_MODE_EN
                        decrypt <= Mode;
`endif
                    end
                end
                ROUND: begin
                    l   <= l_next;
                    r   <= r_next;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        Plaintext <= ip_1_out;
                        Pt_valid  <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (pt_hs) begin
                        Pt_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A beat landing on index 0 of a full table starts a fresh reload.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wptr      <= '0;
            Rk_loaded <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                keys[i] <= '0;
            end
        end else if (rk_hs) begin
            keys[wptr] <= Rk_data;
            wptr       <= wptr + 4'd1;
            if (wptr == 4'd15) begin
                Rk_loaded <= 1'b1;
            end else if (wptr == 4'd0 && Rk_loaded) begin
                Rk_loaded <= 1'b0;
            end
        end
    end
endmodule
